counter_chain_sequencer: RTL and testbench

//  Command-driven controller for the six-counter chain datapath. Accepts one

---
 rtl/counter_chain_sequencer.sv | 130 +++++++++++++
 tb/tb_counter_chain_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/counter_chain_sequencer.sv
// Command-driven sequencer for the six-counter chain: loads, increments, waits out
// the chain latency and checks the modulo-8 result, parking in FAULT on chain error.
module counter_chain_sequencer #(
  parameter int CNT_W    = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_load,
  input  logic [CNT_W-1:0] cmd_inc_cnt,
  output logic             rsp_valid,
  output logic             rsp_pass,
  output logic [2:0]       rsp_value,
  input  logic             clr_fault,
  output logic             fault,
  output logic             dp_rst_n,
  output logic             dp_ld,
  output logic             dp_inc,
  output logic [2:0]       dp_data_in,
  input  logic [2:0]       dp_data_out,
  input  logic             dp_error
);

  localparam int TMR_W = (CNT_W >= 8) ? CNT_W + 1 : 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INC   = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_FAULT = 3'd5,
    S_CLEAR = 3'd6
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [2:0]         load_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [TMR_W-1:0]   timer_r;
  logic               accept_s;
  logic               err_s;
  logic               inc_last_s;
  logic               wait_last_s;
  logic               check_ok_s;
  logic [2:0]         expected_s;

  // Expected chain value: 3-bit wrap-around sum, upper increment-count bits dropped.
  function automatic logic [2:0] exp_sum(input logic [2:0] ld, input logic [CNT_W-1:0] cnt);
    logic [2:0] cnt3;
    cnt3 = 3'(cnt);
    return ld + cnt3;
  endfunction

  assign accept_s    = cmd_valid & cmd_ready;
  assign err_s       = dp_error & (state_r != S_FAULT) & (state_r != S_CLEAR);
  assign inc_last_s  = (TMR_W'(cnt_r) == (timer_r + TMR_W'(1)));
  assign wait_last_s = (timer_r == TMR_W'(PIPE_LAT - 1));
  assign check_ok_s  = (state_r == S_CHECK) & ~err_s;
  assign expected_s  = exp_sum(load_r, cnt_r);

  // Next-state logic; a chain error pre-empts every non-fault state.
  always_comb begin
    state_nxt_s = state_r;
    if (err_s) begin
      state_nxt_s = S_FAULT;
    end else begin
      case (state_r)
        S_IDLE:  state_nxt_s = accept_s ? S_LOAD : S_IDLE;
        S_LOAD:  state_nxt_s = (cnt_r != {CNT_W{1'b0}}) ? S_INC : S_WAIT;
        S_INC:   state_nxt_s = inc_last_s ? S_WAIT : S_INC;
        S_WAIT:  state_nxt_s = wait_last_s ? S_CHECK : S_WAIT;
        S_CHECK: state_nxt_s = S_IDLE;
        S_FAULT: state_nxt_s = clr_fault ? S_CLEAR : S_FAULT;
        S_CLEAR: state_nxt_s = S_IDLE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // State, command latch and dwell timer (counts cycles spent in INC/WAIT).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      load_r  <= 3'd0;
      cnt_r   <= {CNT_W{1'b0}};
      timer_r <= {TMR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        load_r <= cmd_load;
        cnt_r  <= cmd_inc_cnt;
      end
      if ((state_nxt_s == state_r) && ((state_r == S_INC) || (state_r == S_WAIT))) begin
        timer_r <= timer_r + TMR_W'(1);
      end else begin
        timer_r <= {TMR_W{1'b0}};
      end
    end
  end

  // Registered outputs: strobes follow the next state so an error drops them at once;
  // the response captures dp_data_out while in CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready  <= 1'b0;
      dp_ld      <= 1'b0;
      dp_inc     <= 1'b0;
      dp_data_in <= 3'd0;
      dp_rst_n   <= 1'b0;
      fault      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_pass   <= 1'b0;
      rsp_value  <= 3'd0;
    end else begin
      cmd_ready  <= (state_nxt_s == S_IDLE);
      dp_ld      <= (state_nxt_s == S_LOAD);
      dp_inc     <= (state_nxt_s == S_INC);
      dp_data_in <= (state_nxt_s == S_LOAD) ? cmd_load : 3'd0;
      dp_rst_n   <= (state_nxt_s != S_CLEAR);
      fault      <= (state_nxt_s == S_FAULT);
      rsp_valid  <= check_ok_s;
      rsp_pass   <= check_ok_s & (dp_data_out == expected_s);
      rsp_value  <= check_ok_s ? dp_data_out : 3'd0;
    end
  end

endmodule

// File: tb/tb_counter_chain_sequencer.sv
// Directed bench for counter_chain_sequencer with a behavioural counter-chain model
// and hand-computed expected results.
module tb_counter_chain_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_load = 3'd0;
  logic [3:0] cmd_inc_cnt = 4'd0;
  logic       rsp_valid;
  logic       rsp_pass;
  logic [2:0] rsp_value;
  logic       clr_fault = 1'b0;
  logic       fault;
  logic       dp_rst_n;
  logic       dp_ld;
  logic       dp_inc;
  logic [2:0] dp_data_in;
  logic [2:0] dp_data_out;
  logic       dp_error = 1'b0;

  logic [2:0] chain_q_r;
  logic       force_zero = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  counter_chain_sequencer #(.CNT_W(4), .PIPE_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_inc_cnt(cmd_inc_cnt),
    .rsp_valid(rsp_valid), .rsp_pass(rsp_pass), .rsp_value(rsp_value),
    .clr_fault(clr_fault), .fault(fault),
    .dp_rst_n(dp_rst_n), .dp_ld(dp_ld), .dp_inc(dp_inc),
    .dp_data_in(dp_data_in), .dp_data_out(dp_data_out), .dp_error(dp_error)
  );

  always #5 clk = ~clk;

  // Counter chain stand-in: load/increment on the strobes, cleared by dp_rst_n.
  always @(posedge clk) begin
    if (!dp_rst_n) chain_q_r <= 3'd0;
    else if (dp_ld) chain_q_r <= dp_data_in;
    else if (dp_inc) chain_q_r <= chain_q_r + 3'd1;
  end

  assign dp_data_out = force_zero ? 3'd0 : chain_q_r;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one command and check strobes, latency and response.
  task automatic run_cmd(input logic [2:0] ld, input logic [3:0] cnt,
                         input logic [2:0] exp_v, input logic exp_p);
    int ld_cycles, inc_cycles, overlap, rsp_at;
    logic [2:0] v;
    logic p;
    ld_cycles = 0; inc_cycles = 0; overlap = 0; rsp_at = -1; v = 3'd0; p = 1'b0;
    @(negedge clk);
    chk_eq("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_inc_cnt = cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 40 && rsp_at < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (dp_ld) ld_cycles++;
      if (dp_inc) inc_cycles++;
      if (dp_ld && dp_inc) overlap++;
      if (rsp_valid) begin rsp_at = k; v = rsp_value; p = rsp_pass; end
    end
    chk_eq("ld_cycles", ld_cycles, 32'd1);
    chk_eq("inc_cycles", inc_cycles, {28'd0, cnt});
    chk_eq("ld_inc_overlap", overlap, 32'd0);
    chk_eq("rsp_latency", rsp_at, {28'd0, cnt} + 32'd4);
    chk_eq("rsp_value", {29'd0, v}, {29'd0, exp_v});
    chk_eq("rsp_pass", {31'd0, p}, {31'd0, exp_p});
    chk_eq("no_fault", {31'd0, fault}, 32'd0);
    chk_eq("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    chk_eq("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int rsp_seen, ld_seen, seen_inc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk_eq("rst_dp_rst_n", {31'd0, dp_rst_n}, 32'd0);
    chk_eq("rst_strobes", {30'd0, dp_ld, dp_inc}, 32'd0);
    chk_eq("rst_rsp", {27'd0, rsp_valid, rsp_pass, rsp_value}, 32'd0);
    chk_eq("rst_fault", {31'd0, fault}, 32'd0);
    chk_eq("rst_data_in", {29'd0, dp_data_in}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_eq("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk_eq("post_rst_dp_rst_n", {31'd0, dp_rst_n}, 32'd1);

    // Normal commands
    run_cmd(3'd3, 4'd2, 3'd5, 1'b1);
    run_cmd(3'd6, 4'd5, 3'd3, 1'b1);
    run_cmd(3'd4, 4'd0, 3'd4, 1'b1);

    // Chain error during INC
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 3'd2; cmd_inc_cnt = 4'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !dp_inc; k++) begin @(posedge clk); #1; end
    chk_eq("inc_before_err", {31'd0, dp_inc}, 32'd1);
    dp_error = 1'b1;
    @(posedge clk); #1;
    chk_eq("err_fault", {31'd0, fault}, 32'd1);
    chk_eq("err_inc_drop", {31'd0, dp_inc}, 32'd0);
    chk_eq("err_ready", {31'd0, cmd_ready}, 32'd0);
    chk_eq("err_no_rsp", {31'd0, rsp_valid}, 32'd0);
    dp_error = 1'b0;
    cmd_valid = 1'b1;
    rsp_seen = 0; ld_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_seen++;
      if (dp_ld) ld_seen++;
    end
    chk_eq("fault_no_rsp", rsp_seen, 32'd0);
    chk_eq("fault_ignores_cmd", ld_seen, 32'd0);
    chk_eq("fault_held", {31'd0, fault}, 32'd1);
    chk_eq("fault_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    clr_fault = 1'b1;
    @(posedge clk); #1;
    clr_fault = 1'b0;
    chk_eq("clear_dp_rst_n", {31'd0, dp_rst_n}, 32'd0);
    chk_eq("clear_fault_low", {31'd0, fault}, 32'd0);
    chk_eq("clear_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk_eq("after_clear_dp_rst_n", {31'd0, dp_rst_n}, 32'd1);
    chk_eq("after_clear_ready", {31'd0, cmd_ready}, 32'd1);

    // Wrong chain output gives a failing response, not a fault
    force_zero = 1'b1;
    run_cmd(3'd1, 4'd1, 3'd0, 1'b0);
    force_zero = 1'b0;

    // Reset during WAIT aborts the command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 3'd5; cmd_inc_cnt = 4'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    seen_inc = 0;
    for (int k = 0; k < 20; k++) begin
      if (dp_inc) seen_inc = 1;
      else if (seen_inc != 0) break;
      @(posedge clk); #1;
    end
    chk_eq("reached_wait", seen_inc, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_eq("midrst_ready", {31'd0, cmd_ready}, 32'd0);
    chk_eq("midrst_dp_rst_n", {31'd0, dp_rst_n}, 32'd0);
    chk_eq("midrst_outputs", {25'd0, rsp_valid, rsp_pass, rsp_value, dp_ld, dp_inc}, 32'd0);
    @(posedge clk); #1;
    chk_eq("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_eq("midrst_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk_eq("midrst_no_rsp_after", {31'd0, rsp_valid}, 32'd0);
    run_cmd(3'd5, 4'd3, 3'd0, 1'b1);
    run_cmd(3'd7, 4'd15, 3'd6, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
